// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: alignment check, word-wide req/ack bus with byte enables.
// Occupancy is 3 cycles minimum (accept, request, response); stalls upstream for accept and request cycles.
module mem_access_unit #(
    parameter int DWIDTH       = 32,
    parameter int AWIDTH       = 32,
    parameter int OPCODE_WIDTH = 6,
    parameter int TIMEOUT      = 16
) (
    input  logic                    ma_i_clk,
    input  logic                    ma_i_rst_n,
    input  logic                    ma_i_valid,
    input  logic [OPCODE_WIDTH-1:0] ma_i_opcode,
    input  logic [AWIDTH-1:0]       ma_i_addr,
    input  logic [DWIDTH-1:0]       ma_i_store_data,
    output logic                    ma_o_stall,
    output logic                    ma_o_mem_req,
    output logic                    ma_o_mem_we,
    output logic [AWIDTH-1:0]       ma_o_mem_addr,
    output logic [DWIDTH-1:0]       ma_o_mem_wdata,
    output logic [3:0]              ma_o_mem_be,
    input  logic                    ma_i_mem_ack,
    input  logic [DWIDTH-1:0]       ma_i_mem_rdata,
    output logic                    ma_o_load_valid,
    output logic [DWIDTH-1:0]       ma_o_load_data,
    output logic [OPCODE_WIDTH-1:0] ma_o_opcode,
    output logic                    ma_o_misalign,
    output logic                    ma_o_timeout
);
    localparam logic [OPCODE_WIDTH-1:0] OP_LB  = 'h20;
    localparam logic [OPCODE_WIDTH-1:0] OP_LH  = 'h21;
    localparam logic [OPCODE_WIDTH-1:0] OP_LW  = 'h23;
    localparam logic [OPCODE_WIDTH-1:0] OP_LBU = 'h24;
    localparam logic [OPCODE_WIDTH-1:0] OP_LHU = 'h25;
    localparam logic [OPCODE_WIDTH-1:0] OP_SB  = 'h28;
    localparam logic [OPCODE_WIDTH-1:0] OP_SH  = 'h29;
    localparam logic [OPCODE_WIDTH-1:0] OP_SW  = 'h2B;
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [1:0] SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    req_q, req_d, we_q, we_d;
    logic [AWIDTH-1:0]       addr_q, addr_d;
    logic [DWIDTH-1:0]       wdata_q, wdata_d;
    logic [3:0]              be_q, be_d;
    logic [1:0]              lane_q, lane_d, size_q, size_d;
    logic                    ld_q, ld_d;
    logic [OPCODE_WIDTH-1:0] op_q, op_d;
    logic                    load_valid_q, load_valid_d;
    logic [DWIDTH-1:0]       load_data_q, load_data_d;
    logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
    logic                    misalign_q, misalign_d, timeout_q, timeout_d;

    logic                    is_load, is_mem, aligned, accept;
    logic [1:0]              size_in;
    logic [DWIDTH-1:0]       rdata_al;

    always_comb begin
        is_load = 1'b0;
        is_mem  = 1'b1;
        size_in = SZ_WORD;
        case (ma_i_opcode)
            OP_LB, OP_LBU: begin is_load = 1'b1; size_in = SZ_BYTE; end
            OP_LH, OP_LHU: begin is_load = 1'b1; size_in = SZ_HALF; end
            OP_LW:         begin is_load = 1'b1; size_in = SZ_WORD; end
            OP_SB:         size_in = SZ_BYTE;
            OP_SH:         size_in = SZ_HALF;
            OP_SW:         size_in = SZ_WORD;
            default:       is_mem = 1'b0;
        endcase
        case (size_in)
            SZ_WORD: aligned = (ma_i_addr[1:0] == 2'b00);
            SZ_HALF: aligned = ~ma_i_addr[0];
            default: aligned = 1'b1;
        endcase
        accept = (state_q == S_IDLE) && ma_i_valid && is_mem && aligned;
    end

    // Read data shifted down so the addressed lane lands at bit 0.
    always_comb begin
        case (size_q)
            SZ_BYTE: rdata_al = {{(DWIDTH-8){1'b0}},  ma_i_mem_rdata[{lane_q, 3'b000} +: 8]};
            SZ_HALF: rdata_al = {{(DWIDTH-16){1'b0}}, ma_i_mem_rdata[{lane_q[1], 4'b0000} +: 16]};
            default: rdata_al = ma_i_mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        lane_d       = lane_q;
        size_d       = size_q;
        ld_d         = ld_q;
        op_d         = op_q;
        load_valid_d = 1'b0;
        load_data_d  = load_data_q;
        opcode_d     = opcode_q;
        misalign_d   = 1'b0;
        timeout_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ma_i_valid && is_mem && !aligned) begin
                    misalign_d = 1'b1;
                end else if (accept) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = ~is_load;
                    addr_d  = {ma_i_addr[AWIDTH-1:2], 2'b00};
                    lane_d  = ma_i_addr[1:0];
                    size_d  = size_in;
                    ld_d    = is_load;
                    op_d    = ma_i_opcode;
                    case (size_in)
                        SZ_BYTE: begin
                            wdata_d = {4{ma_i_store_data[7:0]}};
                            be_d    = is_load ? 4'b1111 : (4'b0001 << ma_i_addr[1:0]);
                        end
                        SZ_HALF: begin
                            wdata_d = {2{ma_i_store_data[15:0]}};
                            be_d    = is_load ? 4'b1111 : (ma_i_addr[1] ? 4'b1100 : 4'b0011);
                        end
                        default: begin
                            wdata_d = ma_i_store_data;
                            be_d    = 4'b1111;
                        end
                    endcase
                end
            end
            S_ACCESS: begin
                if (ma_i_mem_ack) begin
                    state_d  = S_RESP;
                    req_d    = 1'b0;
                    opcode_d = op_q;
                    if (ld_q) begin
                        load_valid_d = 1'b1;
                        load_data_d  = rdata_al;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = S_RESP;
                    req_d     = 1'b0;
                    opcode_d  = op_q;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ma_i_clk) begin
        if (!ma_i_rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            lane_q       <= '0;
            size_q       <= '0;
            ld_q         <= 1'b0;
            op_q         <= '0;
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
            opcode_q     <= '0;
            misalign_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            lane_q       <= lane_d;
            size_q       <= size_d;
            ld_q         <= ld_d;
            op_q         <= op_d;
            load_valid_q <= load_valid_d;
            load_data_q  <= load_data_d;
            opcode_q     <= opcode_d;
            misalign_q   <= misalign_d;
            timeout_q    <= timeout_d;
        end
    end

    // Gated by reset so upstream never sees a stall while the FSM is being cleared.
    assign ma_o_stall      = ma_i_rst_n && ((state_q == S_ACCESS) || accept);
    assign ma_o_mem_req    = req_q;
    assign ma_o_mem_we     = we_q;
    assign ma_o_mem_addr   = addr_q;
    assign ma_o_mem_wdata  = wdata_q;
    assign ma_o_mem_be     = be_q;
    assign ma_o_load_valid = load_valid_q;
    assign ma_o_load_data  = load_data_q;
    assign ma_o_opcode     = opcode_q;
    assign ma_o_misalign   = misalign_q;
    assign ma_o_timeout    = timeout_q;
endmodule
